// File: rtl/datamem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, the issue-stage request record
// and the widths of the 16-bit data memory it fronts.
package datamem_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;
  localparam int LOCK_CNT_W = 8;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic                  owner;
  } mem_req_t;

endpackage

// File: rtl/datamem_rr_pick.sv
// Combinational two-way grant pick: round-robin or fixed priority in ARB,
// exclusive grant to the lock holder in HOLD0/HOLD1 until the lock budget runs out.
module datamem_rr_pick
  import datamem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int LOCK_MAX   = 8
) (
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  rr_ptr,
  input  arb_state_t            state,
  input  logic [LOCK_CNT_W-1:0] lock_cnt,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  force_release
);

  logic lock_full;

  assign lock_full = (lock_cnt == LOCK_CNT_W'(LOCK_MAX));

  always_comb begin
    gnt           = '0;
    force_release = 1'b0;
    unique case (state)
      // An exhausted lock yields one dead cycle so the waiting side wins the next pick.
      HOLD0: begin
        if (lock_full && req[1]) force_release = 1'b1;
        else                     gnt[0] = req[0];
      end
      HOLD1: begin
        if (lock_full && req[0]) force_release = 1'b1;
        else                     gnt[1] = req[1];
      end
      default: begin
        if (req[0] && req[1]) begin
          if ((FIXED_PRIO != 0) || !rr_ptr) gnt[0] = 1'b1;
          else                              gnt[1] = 1'b1;
        end else begin
          gnt = req;
        end
      end
    endcase
  end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port arbiter and single-stage access sequencer for the 16-bit data memory.
// Reads return to the owning port two edges after acceptance; bounded lock for bursts.
module datamem_arbiter
  import datamem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0,
  parameter int LOCK_MAX   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r0_lock,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic              r1_lock,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  if (ADDR_W != MEM_ADDR_W || DATA_W != MEM_DATA_W) begin : g_width_check
    $error("datamem_arbiter: ADDR_W/DATA_W must match the 16-bit data memory");
  end

  arb_state_t            state_q, state_d;
  logic                  rr_ptr_q, rr_ptr_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  mem_req_t              issue_p1_q, issue_p1_d;
  logic                  vld_p1_q, vld_p1_d;
  logic                  r0_rvalid_q, r0_rvalid_d;
  logic                  r1_rvalid_q, r1_rvalid_d;
  logic [DATA_W-1:0]     r0_rdata_q, r0_rdata_d;
  logic [DATA_W-1:0]     r1_rdata_q, r1_rdata_d;

  logic [NUM_REQ-1:0] req, gnt_pick, gnt, accept;
  logic               force_release;
  logic               acc_any, acc_owner, acc_lock, hold_other, rd_done;

  assign req = {r1_req, r0_req};

  datamem_rr_pick #(
    .FIXED_PRIO(FIXED_PRIO),
    .LOCK_MAX  (LOCK_MAX)
  ) u_pick (
    .req          (req),
    .rr_ptr       (rr_ptr_q),
    .state        (state_q),
    .lock_cnt     (lock_cnt_q),
    .gnt          (gnt_pick),
    .force_release(force_release)
  );

  assign gnt        = gnt_pick & {NUM_REQ{reset}};
  assign accept     = req & gnt;
  assign acc_any    = |accept;
  assign acc_owner  = accept[1];
  assign acc_lock   = acc_owner ? r1_lock : r0_lock;
  assign hold_other = (state_q == HOLD0);

  assign r0_gnt = gnt[0];
  assign r1_gnt = gnt[1];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      ARB: begin
        if (acc_any) begin
          rr_ptr_d = ~acc_owner;
          if (acc_lock) begin
            state_d    = acc_owner ? HOLD1 : HOLD0;
            lock_cnt_d = LOCK_CNT_W'(1);
          end
        end
      end
      HOLD0, HOLD1: begin
        if (force_release) begin
          state_d    = ARB;
          rr_ptr_d   = hold_other;
          lock_cnt_d = '0;
        end else if (!acc_any || !acc_lock) begin
          // Holder went idle or ended its burst.
          state_d    = ARB;
          lock_cnt_d = '0;
        end else if (lock_cnt_q < LOCK_CNT_W'(LOCK_MAX)) begin
          lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    issue_p1_d = issue_p1_q;
    vld_p1_d   = acc_any;
    if (acc_any) begin
      issue_p1_d.owner = acc_owner;
      issue_p1_d.we    = acc_owner ? r1_we    : r0_we;
      issue_p1_d.addr  = acc_owner ? r1_addr  : r0_addr;
      issue_p1_d.wdata = acc_owner ? r1_wdata : r0_wdata;
    end
  end

  // Read data is captured at the end of the issue cycle and steered to its owner only.
  always_comb begin
    rd_done     = vld_p1_q & ~issue_p1_q.we;
    r0_rvalid_d = rd_done & ~issue_p1_q.owner;
    r1_rvalid_d = rd_done &  issue_p1_q.owner;
    r0_rdata_d  = r0_rvalid_d ? mem_read_data : r0_rdata_q;
    r1_rdata_d  = r1_rvalid_d ? mem_read_data : r1_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ARB;
      rr_ptr_q    <= 1'b0;
      lock_cnt_q  <= '0;
      issue_p1_q  <= '0;
      vld_p1_q    <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_cnt_q  <= lock_cnt_d;
      // issue stage (p1)
      issue_p1_q  <= issue_p1_d;
      vld_p1_q    <= vld_p1_d;
      // read return stage (p2)
      r0_rvalid_q <= r0_rvalid_d;
      r1_rvalid_q <= r1_rvalid_d;
      r0_rdata_q  <= r0_rdata_d;
      r1_rdata_q  <= r1_rdata_d;
    end
  end

  assign mem_address      = issue_p1_q.addr;
  assign mem_write_data   = issue_p1_q.wdata;
  assign mem_write_enable = vld_p1_q &  issue_p1_q.we;
  assign mem_read_enable  = vld_p1_q & ~issue_p1_q.we;

  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter: a round-robin instance on a behavioural memory
// plus a fixed-priority instance sharing the same request stimulus.
module tb_datamem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [15:0] r0_addr, r0_wdata, r1_addr, r1_wdata;

  logic r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [15:0] r0_rdata, r1_rdata;
  logic [15:0] mem_address, mem_write_data, mem_read_data;
  logic mem_write_enable, mem_read_enable;

  logic fp_r0_gnt, fp_r0_rvalid, fp_r1_gnt, fp_r1_rvalid;
  logic [15:0] fp_r0_rdata, fp_r1_rdata, fp_mem_address, fp_mem_wdata, fp_mem_rdata;
  logic fp_mem_we, fp_mem_re;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address];
  always @(posedge clk) if (mem_write_enable) mem[mem_address] <= mem_write_data;
  assign fp_mem_rdata = 16'h0000;

  datamem_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(0), .LOCK_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_lock(r0_lock),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_lock(r1_lock),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  datamem_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(1), .LOCK_MAX(8)) dut_fp (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_lock(r0_lock),
    .r0_gnt(fp_r0_gnt), .r0_rvalid(fp_r0_rvalid), .r0_rdata(fp_r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_lock(r1_lock),
    .r1_gnt(fp_r1_gnt), .r1_rvalid(fp_r1_rvalid), .r1_rdata(fp_r1_rdata),
    .mem_address(fp_mem_address), .mem_write_enable(fp_mem_we),
    .mem_read_enable(fp_mem_re), .mem_write_data(fp_mem_wdata),
    .mem_read_data(fp_mem_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
    tick; tick;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; r0_req = 1; r1_req = 1;
    #1;
    checks++;
    if ({r0_gnt, r1_gnt, fp_r0_gnt, fp_r1_gnt} !== 4'b0000) begin
      errors++; $display("FAIL reset_gnt: got %b want 0000", {r0_gnt, r1_gnt, fp_r0_gnt, fp_r1_gnt});
    end
    tick; tick;
    checks++;
    if ({r0_rvalid, r1_rvalid, mem_write_enable, mem_read_enable} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000",
                         {r0_rvalid, r1_rvalid, mem_write_enable, mem_read_enable});
    end
    checks++;
    if ({mem_address, mem_write_data, r0_rdata, r1_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {mem_address, mem_write_data, r0_rdata, r1_rdata});
    end
    checks++;
    if ({fp_r0_rvalid, fp_r1_rvalid, fp_mem_we, fp_mem_re, fp_mem_address, fp_mem_wdata,
         fp_r0_rdata, fp_r1_rdata} !== 68'h0) begin
      errors++; $display("FAIL reset_fp_outputs: got %h want 0", {fp_r0_rvalid, fp_r1_rvalid,
                         fp_mem_we, fp_mem_re, fp_mem_address, fp_mem_wdata, fp_r0_rdata, fp_r1_rdata});
    end
    r0_req = 0; r1_req = 0;
    reset = 1'b1;
  endtask

  task automatic test_basic_rw;
    do_reset;
    r0_req = 1; r0_we = 1; r0_addr = 16'h0010; r0_wdata = 16'hBEEF;
    #1;
    checks++;
    if (r0_gnt !== 1'b1) begin errors++; $display("FAIL basic_gnt: got %b want 1", r0_gnt); end
    tick;
    r0_we = 0;
    #1;
    checks++;
    if ({mem_write_enable, mem_read_enable, mem_address, mem_write_data} !== {2'b10, 16'h0010, 16'hBEEF}) begin
      errors++; $display("FAIL basic_write_issue: got %b %b %h %h want 1 0 0010 beef",
                         mem_write_enable, mem_read_enable, mem_address, mem_write_data);
    end
    tick;
    r0_req = 0;
    #1;
    checks++;
    if ({mem_write_enable, mem_read_enable, r0_rvalid} !== 3'b010) begin
      errors++; $display("FAIL basic_read_issue: got we=%b re=%b rv=%b want 0 1 0",
                         mem_write_enable, mem_read_enable, r0_rvalid);
    end
    tick;
    checks++;
    if ({r0_rvalid, r1_rvalid, r0_rdata} !== {2'b10, 16'hBEEF}) begin
      errors++; $display("FAIL basic_rvalid: got rv0=%b rv1=%b rdata=%h want 1 0 beef",
                         r0_rvalid, r1_rvalid, r0_rdata);
    end
    tick;
    checks++;
    if ({r0_rvalid, mem_read_enable, mem_write_enable, r0_rdata, mem_address} !== {3'b000, 16'hBEEF, 16'h0010}) begin
      errors++; $display("FAIL basic_idle_hold: got rv=%b re=%b we=%b rdata=%h addr=%h want 0 0 0 beef 0010",
                         r0_rvalid, mem_read_enable, mem_write_enable, r0_rdata, mem_address);
    end
  endtask

  task automatic test_round_robin;
    logic exp_g0, exp_g1, exp_v0, exp_v1;
    do_reset;
    r0_addr = 16'h0020; r0_wdata = 16'h1111;
    r1_addr = 16'h0030; r1_wdata = 16'h2222;
    for (int k = 0; k < 8; k++) begin
      r0_req = (k < 6); r1_req = (k < 6);
      r0_we  = (k < 2); r1_we  = (k < 2);
      #1;
      exp_g0 = (k < 6) && (k % 2 == 0);
      exp_g1 = (k < 6) && (k % 2 == 1);
      exp_v0 = (k >= 4) && (k % 2 == 0);
      exp_v1 = (k >= 4) && (k % 2 == 1);
      checks++;
      if ({r0_gnt, r1_gnt} !== {exp_g0, exp_g1}) begin
        errors++; $display("FAIL rr_gnt[%0d]: got %b%b want %b%b", k, r0_gnt, r1_gnt, exp_g0, exp_g1);
      end
      checks++;
      if ({r0_rvalid, r1_rvalid} !== {exp_v0, exp_v1}) begin
        errors++; $display("FAIL rr_rvalid[%0d]: got %b%b want %b%b", k, r0_rvalid, r1_rvalid, exp_v0, exp_v1);
      end
      if (exp_v0) begin
        checks++;
        if (r0_rdata !== 16'h1111) begin errors++; $display("FAIL rr_r0_rdata[%0d]: got %h want 1111", k, r0_rdata); end
      end
      if (exp_v1) begin
        checks++;
        if (r1_rdata !== 16'h2222) begin errors++; $display("FAIL rr_r1_rdata[%0d]: got %h want 2222", k, r1_rdata); end
      end
      tick;
    end
  endtask

  task automatic test_lock_burst;
    logic exp_g0, exp_g1;
    int r1_run;
    do_reset;
    r0_addr = 16'h0040; r1_addr = 16'h0050; r1_lock = 1;
    r1_run = 0;
    for (int k = 0; k < 12; k++) begin
      r0_req = 1; r1_req = 1;
      #1;
      exp_g0 = (k == 0) || (k == 10);
      exp_g1 = ((k >= 1) && (k <= 8)) || (k == 11);
      if (k >= 1 && k <= 9 && r1_gnt) r1_run++;
      checks++;
      if ({r0_gnt, r1_gnt} !== {exp_g0, exp_g1}) begin
        errors++; $display("FAIL lock_gnt[%0d]: got %b%b want %b%b", k, r0_gnt, r1_gnt, exp_g0, exp_g1);
      end
      tick;
    end
    checks++;
    if (r1_run != 8) begin errors++; $display("FAIL lock_run_len: got %0d want 8", r1_run); end
    r0_req = 0; r1_req = 0; r1_lock = 0;
    tick;
  endtask

  task automatic test_fixed_prio;
    do_reset;
    r0_addr = 16'h0060; r1_addr = 16'h0070;
    for (int k = 0; k < 4; k++) begin
      r0_req = 1; r1_req = 1;
      #1;
      checks++;
      if ({fp_r0_gnt, fp_r1_gnt} !== 2'b10) begin
        errors++; $display("FAIL fixed_prio_gnt[%0d]: got %b%b want 10", k, fp_r0_gnt, fp_r1_gnt);
      end
      tick;
    end
    r0_req = 0; r1_req = 0;
  endtask

  task automatic test_reset_discard;
    do_reset;
    r0_req = 1; r0_we = 0; r0_addr = 16'h0010;
    tick;
    reset = 1'b0;
    #1;
    checks++;
    if (r0_gnt !== 1'b0) begin errors++; $display("FAIL discard_gnt: got %b want 0", r0_gnt); end
    for (int k = 0; k < 2; k++) begin
      tick;
      checks++;
      if ({r0_rvalid, r1_rvalid, mem_read_enable, mem_write_enable} !== 4'b0000) begin
        errors++; $display("FAIL discard_in_reset[%0d]: got %b want 0000", k,
                           {r0_rvalid, r1_rvalid, mem_read_enable, mem_write_enable});
      end
    end
    reset = 1'b1; r0_req = 0;
    for (int k = 0; k < 2; k++) begin
      tick;
      checks++;
      if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
        errors++; $display("FAIL discard_no_rvalid[%0d]: got %b%b want 00", k, r0_rvalid, r1_rvalid);
      end
    end
    r0_req = 1; r1_req = 1;
    #1;
    checks++;
    if ({r0_gnt, r1_gnt} !== 2'b10) begin
      errors++; $display("FAIL discard_rr_ptr: got %b%b want 10", r0_gnt, r1_gnt);
    end
    r0_req = 0; r1_req = 0;
    tick;
  endtask

  task automatic test_raw_cross;
    do_reset;
    r0_req = 1; r0_we = 0; r0_addr = 16'h0010;
    tick;
    r0_we = 1; r0_addr = 16'h00FF; r0_wdata = 16'h1234;
    tick;
    r0_req = 0; r0_we = 0;
    r1_req = 1; r1_we = 0; r1_addr = 16'h00FF;
    #1;
    checks++;
    if ({r0_rvalid, r0_rdata} !== {1'b1, 16'hBEEF}) begin
      errors++; $display("FAIL cross_r0_read: got rv=%b rdata=%h want 1 beef", r0_rvalid, r0_rdata);
    end
    tick;
    r1_req = 0;
    tick;
    checks++;
    if ({r1_rvalid, r1_rdata} !== {1'b1, 16'h1234}) begin
      errors++; $display("FAIL cross_r1_raw: got rv=%b rdata=%h want 1 1234", r1_rvalid, r1_rdata);
    end
    checks++;
    if ({r0_rvalid, r0_rdata} !== {1'b0, 16'hBEEF}) begin
      errors++; $display("FAIL cross_r0_untouched: got rv=%b rdata=%h want 0 beef", r0_rvalid, r0_rdata);
    end
    tick;
  endtask

  initial begin
    reset = 1'b0;
    r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
    tick;
    test_reset;
    test_basic_rw;
    test_round_robin;
    test_lock_burst;
    test_fixed_prio;
    test_reset_discard;
    test_raw_cross;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
